// File: rtl/console_pkg.sv
// Shared types, character classes and cell/address helpers
// for the text console write sequencer.
package console_pkg;

    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } state_t;

    localparam int ROW_W = 6;
    localparam int COL_W = 7;

    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    function automatic logic [31:0] pack_cell(
        input logic [23:0] color,
        input logic [7:0]  ch
    );
        return {color, ch};
    endfunction

    function automatic logic [31:0] make_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        return {19'd0, row, col};
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Char-stream handshake plus frame-buffer write port
// of the text console sequencer.
interface text_console_ctrl_if;
    import console_pkg::*;

    logic              iValid;
    logic              oReady;
    logic [7:0]        iChar;
    logic [23:0]       iColor;
    logic              iClear;
    logic              oBusy;
    logic              oWriteEn;
    logic [31:0]       oWAddr;
    logic [31:0]       oData;
    logic [ROW_W-1:0]  oCurRow;
    logic [COL_W-1:0]  oCurCol;

    modport master (
        output iValid, iChar, iColor, iClear,
        input  oReady, oBusy, oWriteEn, oWAddr,
        input  oData, oCurRow, oCurCol
    );

    modport slave (
        input  iValid, iChar, iColor, iClear,
        output oReady, oBusy, oWriteEn, oWAddr,
        output oData, oCurRow, oCurCol
    );

endinterface

// File: rtl/console_cursor.sv
// Cursor row/col registers over the COLS x ROWS grid.
// Controls are one-hot; wrap past the last row returns to row 0.
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic             iClk,
    input  logic             nRst,
    input  logic             inc,
    input  logic             newline,
    input  logic             cr,
    input  logic             bs,
    input  logic             home,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] nxt_row,
    output logic [COL_W-1:0] nxt_col
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0] row_wrap;

    assign row_wrap = (row == ROW_LAST) ? '0 : row + 1'b1;

    always_comb begin
        nxt_row = row;
        nxt_col = col;
        unique case (1'b1)
            home: begin
                nxt_row = '0;
                nxt_col = '0;
            end
            inc: begin
                if (col == COL_LAST) begin
                    nxt_col = '0;
                    nxt_row = row_wrap;
                end else begin
                    nxt_col = col + 1'b1;
                end
            end
            newline: begin
                nxt_col = '0;
                nxt_row = row_wrap;
            end
            cr: nxt_col = '0;
            bs: begin
                if (col != '0)
                    nxt_col = col - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= nxt_row;
            col <= nxt_col;
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console write sequencer: char stream -> frame buffer cells, plus clear engine.
// Optional: CONSOLE_AUTOCLEAR_EN starts a full-screen clear straight out of reset.
module text_console_ctrl
    import console_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input logic                iClk,
    input logic                nRst,
    text_console_ctrl_if.slave bus
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [31:0] CLR_CELL = pack_cell(24'h0, CLEAR_CHAR);

`ifdef CONSOLE_AUTOCLEAR_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t           state, state_nxt;
    logic             inc, newline, cr, bs, home;
    logic [ROW_W-1:0] row, nxt_row;
    logic [COL_W-1:0] col, nxt_col;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             accept, last_cell;
    logic             is_print, is_lf, is_cr, is_bs;

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .iClk    (iClk),
        .nRst    (nRst),
        .inc     (inc),
        .newline (newline),
        .cr      (cr),
        .bs      (bs),
        .home    (home),
        .row     (row),
        .col     (col),
        .nxt_row (nxt_row),
        .nxt_col (nxt_col)
    );

    assign bus.oReady   = (state == IDLE) & ~bus.iClear;
    assign bus.oBusy    = (state == CLEAR);
    assign bus.oWriteEn = we_q;
    assign bus.oWAddr   = addr_q;
    assign bus.oData    = data_q;
    assign bus.oCurRow  = row;
    assign bus.oCurCol  = col;

    assign accept    = bus.iValid & bus.oReady;
    assign last_cell = (row == ROW_LAST) && (col == COL_LAST);
    assign is_print  = (bus.iChar >= CH_PRINT_LO) &&
                       (bus.iChar <= CH_PRINT_HI);
    assign is_lf     = (bus.iChar == CH_LF);
    assign is_cr     = (bus.iChar == CH_CR);
    assign is_bs     = (bus.iChar == CH_BS);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst)
            state <= RST_STATE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        inc       = 1'b0;
        newline   = 1'b0;
        cr        = 1'b0;
        bs        = 1'b0;
        home      = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        unique case (state)
            IDLE: begin
                if (bus.iClear) begin
                    state_nxt = CLEAR;
                    home      = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = make_addr('0, '0);
                    data_d    = CLR_CELL;
                end else if (accept) begin
                    unique case (1'b1)
                        is_print: begin
                            inc    = 1'b1;
                            we_d   = 1'b1;
                            addr_d = make_addr(row, col);
                            data_d = pack_cell(bus.iColor, bus.iChar);
                        end
                        is_lf:   newline = 1'b1;
                        is_cr:   cr      = 1'b1;
                        is_bs:   bs      = 1'b1;
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                // The cursor names the cell on the bus; no strobe yet
                // means this is the first cycle after a reset-time clear.
                data_d = CLR_CELL;
                if (!we_q) begin
                    we_d   = 1'b1;
                    addr_d = make_addr(row, col);
                end else if (last_cell) begin
                    inc       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    inc    = 1'b1;
                    we_d   = 1'b1;
                    addr_d = make_addr(nxt_row, nxt_col);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: stimulus pushes expected
// writes, a negedge monitor pops and compares every strobe.
module tb_text_console_ctrl;

    logic iClk = 1'b0;
    logic nRst = 1'b0;

    always #5 iClk = ~iClk;

    text_console_ctrl_if bus ();

    text_console_ctrl #(
        .COLS       (80),
        .ROWS       (30),
        .CLEAR_CHAR (8'h20)
    ) dut (
        .iClk (iClk),
        .nRst (nRst),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          clr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   n_strobe = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
    endtask

    function automatic logic [31:0] a(input int r, input int c);
        return {19'd0, 6'(r), 7'(c)};
    endfunction

    always @(negedge iClk) begin
        if (nRst && bus.oWriteEn) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_strobe: addr %0h data %0h, none expected",
                         bus.oWAddr, bus.oData);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("waddr", bus.oWAddr, e.addr);
                chk("wdata", bus.oData, e.data);
                if (e.clr)
                    chk("clr_ready_busy",
                        {bus.oReady, bus.oBusy}, 2'b01);
            end
        end
    end

    task automatic push_w(input logic [31:0] ad,
                          input logic [31:0] dt,
                          input bit cl);
        exp_t e;
        e.addr = ad;
        e.data = dt;
        e.clr  = cl;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                push_w(a(r, c), 32'h0000_0020, 1'b1);
    endtask

    task automatic put_w(input logic [7:0] ch,
                         input logic [23:0] color,
                         input logic [31:0] ad,
                         input logic [31:0] dt);
        bus.iValid = 1'b1;
        bus.iChar  = ch;
        bus.iColor = color;
        push_w(ad, dt, 1'b0);
        @(posedge iClk);
        #1;
    endtask

    task automatic put_n(input logic [7:0] ch);
        bus.iValid = 1'b1;
        bus.iChar  = ch;
        bus.iColor = 24'hABCDEF;
        @(posedge iClk);
        #1;
    endtask

    task automatic idle();
        bus.iValid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 5000) begin
            @(negedge iClk);
            b++;
        end
        repeat (2) @(negedge iClk);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic cur(input string nm, input int r, input int c);
        chk(nm, {bus.oCurRow, bus.oCurCol}, {6'(r), 7'(c)});
    endtask

    initial begin
        int base;
        int b;
        logic [7:0] ch;
        bus.iValid = 1'b0;
        bus.iChar  = 8'h00;
        bus.iColor = 24'h0;
        bus.iClear = 1'b0;

        #12;
        chk("rst_we", bus.oWriteEn, 1'b0);
        chk("rst_addr", bus.oWAddr, 32'h0);
        chk("rst_data", bus.oData, 32'h0);
        cur("rst_cursor", 0, 0);
`ifdef CONSOLE_AUTOCLEAR_EN
        chk("rst_ready_busy", {bus.oReady, bus.oBusy}, 2'b01);
`else
        chk("rst_ready_busy", {bus.oReady, bus.oBusy}, 2'b10);
`endif
        @(negedge iClk);
        nRst = 1'b1;
`ifdef CONSOLE_AUTOCLEAR_EN
        push_clear();
`endif
        drain();
        chk("post_rst_ready", bus.oReady, 1'b1);

        put_w(8'h41, 24'hFF0000, 32'h0, 32'hFF00_0041);
        idle();
        drain();
        cur("cursor_after_A", 0, 1);

        put_n(8'h0D);
        for (int i = 0; i < 79; i++) begin
            ch = 8'h30 + 8'(i % 10);
            put_w(ch, 24'h00FF00, a(0, i), {24'h00FF00, ch});
        end
        put_w(8'h5A, 24'h00FF00, 32'h4F, 32'h00FF_005A);
        idle();
        drain();
        cur("cursor_row_wrap", 1, 0);
        put_w(8'h21, 24'h0A0B0C, 32'h80, 32'h0A0B_0C21);
        idle();
        drain();
        cur("cursor_81st", 1, 1);

        bus.iClear = 1'b1;
        bus.iValid = 1'b1;
        bus.iChar  = 8'h5A;
        push_clear();
        @(posedge iClk);
        #1;
        bus.iClear = 1'b0;
        bus.iValid = 1'b0;
        drain();
        chk("clr_done_flags",
            {bus.oReady, bus.oBusy, bus.oWriteEn}, 3'b100);
        cur("clr_done_cursor", 0, 0);

        for (int i = 0; i < 29; i++)
            put_n(8'h0A);
        idle();
        cur("cursor_29_lf", 29, 0);
        for (int i = 0; i < 79; i++) begin
            ch = 8'h61 + 8'(i % 26);
            put_w(ch, 24'h0000FF, a(29, i), {24'h0000FF, ch});
        end
        put_w(8'h7E, 24'h0000FF, 32'hECF, 32'h0000_FF7E);
        idle();
        drain();
        cur("cursor_top_wrap", 0, 0);

        put_n(8'h0A);
        put_n(8'h0A);
        put_n(8'h0A);
        for (int i = 0; i < 5; i++)
            put_w(8'h2E, 24'h111111, a(3, i), 32'h1111_112E);
        put_w(8'h78, 24'h123456, 32'h185, 32'h1234_5678);
        put_n(8'h08);
        put_n(8'h08);
        put_n(8'h0D);
        put_n(8'h0A);
        idle();
        drain();
        cur("cursor_ctrl_seq", 4, 0);

        put_n(8'h08);
        put_n(8'h7F);
        put_n(8'h1F);
        idle();
        drain();
        cur("cursor_dropped", 4, 0);
        put_w(8'h20, 24'hC0FFEE, 32'h200, 32'hC0FF_EE20);
        idle();
        drain();
        cur("cursor_space", 4, 1);

        base = n_strobe;
        bus.iClear = 1'b1;
        push_clear();
        @(posedge iClk);
        #1;
        bus.iClear = 1'b0;
        b = 0;
        while (n_strobe < base + 1000 && b < 3000) begin
            @(negedge iClk);
            b++;
        end
        chk("midclr_reached", n_strobe >= base + 1000, 1'b1);
        @(posedge iClk);
        #2;
        nRst = 1'b0;
        #1;
        chk("midclr_rst_we", bus.oWriteEn, 1'b0);
        cur("midclr_rst_cursor", 0, 0);
        exp_q.delete();
        @(negedge iClk);
        nRst = 1'b1;
`ifdef CONSOLE_AUTOCLEAR_EN
        push_clear();
        drain();
`else
        repeat (5) @(negedge iClk);
        chk("midclr_ready_busy", {bus.oReady, bus.oBusy}, 2'b10);
        drain();
`endif
        chk("final_flags", {bus.oReady, bus.oWriteEn}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
